// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory with registered load responses.
// Optional `DMEM_ARB_RR_EN selects round-robin instead of fixed priority plus starve counter.
module dmem_arbiter #(
  parameter int P_ADDR_WIDTH   = 11,
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_STARVE_LIMIT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_p0_req,
  input  logic                    i_p0_we,
  input  logic [P_ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [1:0]              i_p0_storetype,
  input  logic [P_DATA_WIDTH-1:0] i_p0_wdata,
  output logic                    o_p0_gnt,
  output logic                    o_p0_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_p0_rdata,
  input  logic                    i_p1_req,
  input  logic                    i_p1_we,
  input  logic [P_ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [1:0]              i_p1_storetype,
  input  logic [P_DATA_WIDTH-1:0] i_p1_wdata,
  output logic                    o_p1_gnt,
  output logic                    o_p1_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_p1_rdata,
  output logic                    o_mem_we,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [1:0]              o_mem_storetype,
  output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

  logic p1_pick;

`ifdef DMEM_ARB_RR_EN
  // last_gnt: 0 = p0 granted last, 1 = p1 granted last
  logic last_gnt;

  assign p1_pick = i_p1_req & (~i_p0_req | ~last_gnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_gnt <= 1'b1;
    end else if (o_p0_gnt) begin
      last_gnt <= 1'b0;
    end else if (o_p1_gnt) begin
      last_gnt <= 1'b1;
    end
  end
`else
  localparam int SW = $clog2(P_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(P_STARVE_LIMIT);

  logic [SW-1:0] starve;

  assign p1_pick = i_p1_req & (~i_p0_req | (starve == STARVE_MAX));

  // Counts consecutive denied p1 cycles; any break in the request or a grant clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve <= '0;
    end else if (!i_p1_req || o_p1_gnt) begin
      starve <= '0;
    end else if (starve != STARVE_MAX) begin
      starve <= starve + 1'b1;
    end
  end
`endif

  assign o_p0_gnt = i_rst_n & i_p0_req & ~p1_pick;
  assign o_p1_gnt = i_rst_n & p1_pick;

  always_comb begin
    o_mem_we        = 1'b0;
    o_mem_addr      = '0;
    o_mem_storetype = 2'b00;
    o_mem_wdata     = '0;
    if (o_p0_gnt) begin
      o_mem_we        = i_p0_we;
      o_mem_addr      = i_p0_addr;
      o_mem_storetype = i_p0_storetype;
      o_mem_wdata     = i_p0_wdata;
    end else if (o_p1_gnt) begin
      o_mem_we        = i_p1_we;
      o_mem_addr      = i_p1_addr;
      o_mem_storetype = i_p1_storetype;
      o_mem_wdata     = i_p1_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_p0_rvalid <= 1'b0;
      o_p1_rvalid <= 1'b0;
      o_p0_rdata  <= '0;
      o_p1_rdata  <= '0;
    end else begin
      o_p0_rvalid <= o_p0_gnt & ~i_p0_we;
      o_p1_rvalid <= o_p1_gnt & ~i_p1_we;
      if (o_p0_gnt && !i_p0_we) o_p0_rdata <= i_mem_rdata;
      if (o_p1_gnt && !i_p1_we) o_p1_rdata <= i_mem_rdata;
    end
  end

endmodule
